// File: rtl/vec_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vec_mem_arbiter
//
// Shares the single-port vector data memory behind the writeback stage between
// the pipeline (CPU port, single-beat loads/stores) and the host loader (HOST
// port, multi-beat bursts with an auto-incrementing address). The CPU has
// priority in IDLE. A starvation counter lets a waiting host take the memory
// after STARVE_LIMIT consecutive denied cycles. Once a burst has started, it
// owns the memory until its last beat or until the host drops host_req.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata   CPU single-beat request
//   cpu_gnt             access performed this cycle (combinational)
//   cpu_rvalid/rdata    load return, one cycle after a granted load
//   host_req/we/addr/len/wdata  host burst request (we/addr/len sampled on beat 0)
//   host_gnt            beat performed this cycle (combinational)
//   host_rvalid/rdata   read beat return, one cycle after a granted read beat
//   host_done           pulse in the grant cycle of the last beat
//   mem_we/addr/wdata   memory command
//   mem_rdata           memory read data, one cycle after the address
// -----------------------------------------------------------------------------
module vec_mem_arbiter #(
  parameter int vecSize      = 4,
  parameter int registerSize = 8,
  parameter int BURST_W      = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cpu_req,
  input  logic                            cpu_we,
  input  logic [registerSize-1:0]         cpu_addr,
  input  logic [vecSize*registerSize-1:0] cpu_wdata,
  output logic                            cpu_gnt,
  output logic                            cpu_rvalid,
  output logic [vecSize*registerSize-1:0] cpu_rdata,
  input  logic                            host_req,
  input  logic                            host_we,
  input  logic [registerSize-1:0]         host_addr,
  input  logic [BURST_W-1:0]              host_len,
  input  logic [vecSize*registerSize-1:0] host_wdata,
  output logic                            host_gnt,
  output logic                            host_rvalid,
  output logic [vecSize*registerSize-1:0] host_rdata,
  output logic                            host_done,
  output logic                            mem_we,
  output logic [registerSize-1:0]         mem_addr,
  output logic [vecSize*registerSize-1:0] mem_wdata,
  input  logic [vecSize*registerSize-1:0] mem_rdata
);

  localparam int DW = vecSize * registerSize;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    IDLE,
    HOST_BURST
  } state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           starve_q, starve_d;
  logic [BURST_W-1:0]      beat_q, beat_d;
  logic [BURST_W-1:0]      len_q, len_d;
  logic [registerSize-1:0] base_q, base_d;
  logic                    we_q, we_d;
  logic                    cpu_rvalid_q, cpu_rvalid_d;
  logic                    host_rvalid_q, host_rvalid_d;
  logic [DW-1:0]           cpu_hold_q, cpu_hold_d;
  logic [DW-1:0]           host_hold_q, host_hold_d;

  logic                    cpu_gnt_c, host_gnt_c, host_done_c, mem_we_c;
  logic [registerSize-1:0] mem_addr_c;
  logic [DW-1:0]           mem_wdata_c;
  logic                    starve_full;

  assign starve_full = (starve_q == SW'(STARVE_LIMIT));

  // Arbitration and burst sequencing. beat_q holds the index of the next
  // burst beat, so the address of the current beat is base_q + beat_q.
  // The starve counter only advances while the host is being denied by the
  // CPU; since that can only happen below the limit, the increment saturates
  // naturally at STARVE_LIMIT.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    beat_d      = beat_q;
    len_d       = len_q;
    base_d      = base_q;
    we_d        = we_q;
    cpu_gnt_c   = 1'b0;
    host_gnt_c  = 1'b0;
    host_done_c = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req && !(host_req && starve_full)) begin
          cpu_gnt_c   = 1'b1;
          mem_we_c    = cpu_we;
          mem_addr_c  = cpu_addr;
          mem_wdata_c = cpu_wdata;
          if (host_req) begin
            starve_d = (starve_full) ? starve_q : starve_q + SW'(1);
          end else begin
            starve_d = '0;
          end
        end else if (host_req) begin
          host_gnt_c  = 1'b1;
          mem_we_c    = host_we;
          mem_addr_c  = host_addr;
          mem_wdata_c = host_wdata;
          base_d      = host_addr;
          we_d        = host_we;
          len_d       = host_len;
          beat_d      = BURST_W'(1);
          starve_d    = '0;
          if (host_len == '0) begin
            host_done_c = 1'b1;
          end else begin
            state_d = HOST_BURST;
          end
        end else begin
          starve_d = '0;
        end
      end

      HOST_BURST: begin
        if (host_req) begin
          host_gnt_c  = 1'b1;
          mem_we_c    = we_q;
          mem_addr_c  = base_q + registerSize'(beat_q);
          mem_wdata_c = host_wdata;
          if (beat_q == len_q) begin
            host_done_c = 1'b1;
            state_d     = IDLE;
          end else begin
            beat_d = beat_q + BURST_W'(1);
          end
        end else begin
          // Host abandoned the burst: no grant, no done, back to IDLE.
          state_d  = IDLE;
          starve_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Read return bookkeeping. rvalid marks the cycle in which mem_rdata
  // carries the data for the previous cycle's granted read; the hold
  // registers keep that data visible until the same port reads again.
  always_comb begin
    cpu_rvalid_d  = cpu_gnt_c && !mem_we_c;
    host_rvalid_d = host_gnt_c && !mem_we_c;
    cpu_hold_d    = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
    host_hold_d   = host_rvalid_q ? mem_rdata : host_hold_q;
  end

  // State registers, all cleared by the asynchronous reset; clearing the
  // state also aborts any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      beat_q        <= '0;
      len_q         <= '0;
      base_q        <= '0;
      we_q          <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_hold_q    <= '0;
      host_hold_q   <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      beat_q        <= beat_d;
      len_q         <= len_d;
      base_q        <= base_d;
      we_q          <= we_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      cpu_hold_q    <= cpu_hold_d;
      host_hold_q   <= host_hold_d;
    end
  end

  // Grants, done and write enable are combinational, so they are gated by
  // reset directly to drop the moment reset asserts, without waiting for a clock.
  assign cpu_gnt     = cpu_gnt_c & reset;
  assign host_gnt    = host_gnt_c & reset;
  assign host_done   = host_done_c & reset;
  assign mem_we      = mem_we_c & reset;
  assign mem_addr    = mem_addr_c;
  assign mem_wdata   = mem_wdata_c;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rdata   = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
  assign host_rdata  = host_rvalid_q ? mem_rdata : host_hold_q;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vec_mem_arbiter
//
// Drives vec_mem_arbiter with a zeroed single-port memory model, a table of
// directed per-cycle vectors, a reset-during-burst sequence and a randomized
// traffic phase. Every cycle is compared against a transaction-level
// reference of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_vec_mem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [3:0]    host_len;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid, host_done;
  logic [DW-1:0] host_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  vec_mem_arbiter #(
    .vecSize(4), .registerSize(8), .BURST_W(4), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_done(host_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT: synchronous write, registered read.
  logic [DW-1:0] phys_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) phys_mem[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    mem_rdata <= phys_mem[mem_addr];
    if (mem_we) phys_mem[mem_addr] <= mem_wdata;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached (got timeout, required $finish)");
    $fatal(1);
  end

  // ---------------- reference model (transaction level) ----------------
  logic [DW-1:0] ref_mem [256];
  bit            m_in_burst;
  int            m_k, m_len, m_base, m_starve;
  bit            m_bwe;
  bit            m_crv, m_hrv;
  logic [DW-1:0] m_crd, m_hrd;
  bit            e_cg, e_hg, e_done, e_we;
  int            e_addr;
  logic [DW-1:0] e_wd;

  task automatic modelReset();
    m_in_burst = 0; m_k = 0; m_len = 0; m_base = 0; m_starve = 0; m_bwe = 0;
    m_crv = 0; m_hrv = 0; m_crd = '0; m_hrd = '0;
    e_cg = 0; e_hg = 0; e_done = 0;
  endtask

  // What the memory port should be doing this cycle given the current inputs.
  task automatic modelPredict();
    e_cg = 0; e_hg = 0; e_done = 0; e_we = 0; e_addr = 0; e_wd = '0;
    if (!m_in_burst) begin
      if (cpu_req && !(host_req && m_starve == LIMIT)) begin
        e_cg = 1; e_we = cpu_we; e_addr = int'(cpu_addr); e_wd = cpu_wdata;
      end else if (host_req) begin
        e_hg = 1; e_we = host_we; e_addr = int'(host_addr); e_wd = host_wdata;
        e_done = (host_len == 0);
      end
    end else if (host_req) begin
      e_hg = 1; e_we = m_bwe; e_addr = (m_base + m_k) % 256; e_wd = host_wdata;
      e_done = (m_k == m_len);
    end
  endtask

  // Effect of this cycle's transaction at the clock edge.
  task automatic modelCommit();
    m_crv = 0; m_hrv = 0;
    if (e_cg && !e_we) begin m_crv = 1; m_crd = ref_mem[e_addr]; end
    if (e_hg && !e_we) begin m_hrv = 1; m_hrd = ref_mem[e_addr]; end
    if ((e_cg || e_hg) && e_we) ref_mem[e_addr] = e_wd;
    if (!host_req) m_starve = 0;
    else if (!m_in_burst && e_cg) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else if (!m_in_burst && e_hg) m_starve = 0;
    if (!m_in_burst) begin
      if (e_hg && !e_done) begin
        m_in_burst = 1; m_k = 1; m_len = int'(host_len);
        m_base = int'(host_addr); m_bwe = host_we;
      end
    end else begin
      if (!host_req || e_done) m_in_burst = 0;
      else m_k = m_k + 1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already applied; compare mid-cycle, then
  // advance the model at the edge and return just after it.
  task automatic applyStimulus();
    @(negedge clk);
    modelPredict();
    checkOutput("cpu_gnt", DW'(cpu_gnt), DW'(e_cg));
    checkOutput("host_gnt", DW'(host_gnt), DW'(e_hg));
    checkOutput("host_done", DW'(host_done), DW'(e_done));
    checkOutput("mem_we", DW'(mem_we), DW'(e_we && (e_cg || e_hg)));
    checkOutput("mem_addr", DW'(mem_addr), DW'(e_addr));
    checkOutput("mem_wdata", mem_wdata, e_wd);
    checkOutput("cpu_rvalid", DW'(cpu_rvalid), DW'(m_crv));
    checkOutput("host_rvalid", DW'(host_rvalid), DW'(m_hrv));
    checkOutput("cpu_rdata", cpu_rdata, m_crd);
    checkOutput("host_rdata", host_rdata, m_hrd);
    @(posedge clk);
    modelCommit();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    bit            hreq, hwe;
    logic [AW-1:0] haddr;
    logic [3:0]    hlen;
    logic [DW-1:0] hwd;
    bit            ecg, ehg, edone;
    logic [AW-1:0] eaddr;
    bit            ecrv, ehrv;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t tbl[$];

  task automatic addRow(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                        input logic [DW-1:0] cwd, input bit hreq, input bit hwe,
                        input logic [AW-1:0] haddr, input logic [3:0] hlen,
                        input logic [DW-1:0] hwd, input bit ecg, input bit ehg,
                        input bit edone, input logic [AW-1:0] eaddr, input bit ecrv,
                        input bit ehrv, input logic [DW-1:0] erd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hlen = hlen; v.hwd = hwd;
    v.ecg = ecg; v.ehg = ehg; v.edone = edone; v.eaddr = eaddr;
    v.ecrv = ecrv; v.ehrv = ehrv; v.erd = erd;
    tbl.push_back(v);
  endtask

  task automatic driveIdle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_len = '0; host_wdata = '0;
  endtask

  bit last_hg;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    modelReset();

    // CPU store / load, load of an unwritten word
    addRow(1,1,8'h04,32'hDEADBEEF, 0,0,8'h00,4'd0,32'h0, 1,0,0,8'h04, 0,0,32'h0);
    addRow(1,0,8'h04,32'h0,        0,0,8'h00,4'd0,32'h0, 1,0,0,8'h04, 0,0,32'h0);
    addRow(1,0,8'h00,32'h0,        0,0,8'h00,4'd0,32'h0, 1,0,0,8'h00, 1,0,32'hDEADBEEF);
    addRow(0,0,8'h00,32'h0,        0,0,8'h00,4'd0,32'h0, 0,0,0,8'h00, 1,0,32'h0);
    // host burst write 8..11, CPU readback, host burst read
    addRow(0,0,8'h00,32'h0, 1,1,8'h08,4'd3,32'h11111111, 0,1,0,8'h08, 0,0,32'h0);
    addRow(0,0,8'h00,32'h0, 1,1,8'h08,4'd3,32'h22222222, 0,1,0,8'h09, 0,0,32'h0);
    addRow(0,0,8'h00,32'h0, 1,1,8'h08,4'd3,32'h33333333, 0,1,0,8'h0A, 0,0,32'h0);
    addRow(0,0,8'h00,32'h0, 1,1,8'h08,4'd3,32'h44444444, 0,1,1,8'h0B, 0,0,32'h0);
    addRow(1,0,8'h0A,32'h0, 0,0,8'h00,4'd0,32'h0,        1,0,0,8'h0A, 0,0,32'h0);
    addRow(0,0,8'h00,32'h0, 1,0,8'h08,4'd3,32'h0,        0,1,0,8'h08, 1,0,32'h33333333);
    addRow(0,0,8'h00,32'h0, 1,0,8'h08,4'd3,32'h0,        0,1,0,8'h09, 0,1,32'h11111111);
    addRow(0,0,8'h00,32'h0, 1,0,8'h08,4'd3,32'h0,        0,1,0,8'h0A, 0,1,32'h22222222);
    addRow(0,0,8'h00,32'h0, 1,0,8'h08,4'd3,32'h0,        0,1,1,8'h0B, 0,1,32'h33333333);
    addRow(0,0,8'h00,32'h0, 0,0,8'h00,4'd0,32'h0,        0,0,0,8'h00, 0,1,32'h44444444);
    // starvation: CPU wins exactly LIMIT cycles, then host burst, CPU resumes
    addRow(1,0,8'h20,32'h0, 1,1,8'h30,4'd1,32'hAAAA0000, 1,0,0,8'h20, 0,0,32'h0);
    addRow(1,0,8'h20,32'h0, 1,1,8'h30,4'd1,32'hAAAA0000, 1,0,0,8'h20, 1,0,32'h0);
    addRow(1,0,8'h20,32'h0, 1,1,8'h30,4'd1,32'hAAAA0000, 1,0,0,8'h20, 1,0,32'h0);
    addRow(1,0,8'h20,32'h0, 1,1,8'h30,4'd1,32'hAAAA0000, 1,0,0,8'h20, 1,0,32'h0);
    addRow(1,0,8'h20,32'h0, 1,1,8'h30,4'd1,32'hAAAA0000, 0,1,0,8'h30, 1,0,32'h0);
    addRow(1,0,8'h20,32'h0, 1,1,8'h30,4'd1,32'hAAAA0001, 0,1,1,8'h31, 0,0,32'h0);
    addRow(1,0,8'h20,32'h0, 0,0,8'h00,4'd0,32'h0,        1,0,0,8'h20, 0,0,32'h0);
    addRow(0,0,8'h00,32'h0, 0,0,8'h00,4'd0,32'h0,        0,0,0,8'h00, 1,0,32'h0);
    // address wrap FE, FF, 00, 01
    addRow(0,0,8'h00,32'h0, 1,1,8'hFE,4'd3,32'hA1A1A1A1, 0,1,0,8'hFE, 0,0,32'h0);
    addRow(0,0,8'h00,32'h0, 1,1,8'hFE,4'd3,32'hA2A2A2A2, 0,1,0,8'hFF, 0,0,32'h0);
    addRow(0,0,8'h00,32'h0, 1,1,8'hFE,4'd3,32'hA3A3A3A3, 0,1,0,8'h00, 0,0,32'h0);
    addRow(0,0,8'h00,32'h0, 1,1,8'hFE,4'd3,32'hA4A4A4A4, 0,1,1,8'h01, 0,0,32'h0);
    addRow(1,0,8'h00,32'h0, 0,0,8'h00,4'd0,32'h0,        1,0,0,8'h00, 0,0,32'h0);
    addRow(0,0,8'h00,32'h0, 0,0,8'h00,4'd0,32'h0,        0,0,0,8'h00, 1,0,32'hA3A3A3A3);
    // abort after beat 1 with a pending CPU load
    addRow(0,0,8'h00,32'h0, 1,1,8'h40,4'd3,32'hB0B0B0B0, 0,1,0,8'h40, 0,0,32'h0);
    addRow(1,0,8'h40,32'h0, 1,1,8'h40,4'd3,32'hB1B1B1B1, 0,1,0,8'h41, 0,0,32'h0);
    addRow(1,0,8'h40,32'h0, 0,0,8'h00,4'd0,32'h0,        0,0,0,8'h00, 0,0,32'h0);
    addRow(1,0,8'h40,32'h0, 0,0,8'h00,4'd0,32'h0,        1,0,0,8'h40, 0,0,32'h0);
    addRow(0,0,8'h00,32'h0, 0,0,8'h00,4'd0,32'h0,        0,0,0,8'h00, 1,0,32'hB0B0B0B0);

    // reset state, with requests asserted to show the grants stay low
    driveIdle();
    reset = 0; cpu_req = 1; host_req = 1;
    #12;
    checkOutput("rst_cpu_gnt", DW'(cpu_gnt), '0);
    checkOutput("rst_host_gnt", DW'(host_gnt), '0);
    checkOutput("rst_mem_we", DW'(mem_we), '0);
    checkOutput("rst_host_done", DW'(host_done), '0);
    checkOutput("rst_cpu_rvalid", DW'(cpu_rvalid), '0);
    checkOutput("rst_host_rvalid", DW'(host_rvalid), '0);
    checkOutput("rst_cpu_rdata", cpu_rdata, '0);
    checkOutput("rst_host_rdata", host_rdata, '0);
    driveIdle();
    @(negedge clk); reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr;
      cpu_wdata = tbl[i].cwd; host_req = tbl[i].hreq; host_we = tbl[i].hwe;
      host_addr = tbl[i].haddr; host_len = tbl[i].hlen; host_wdata = tbl[i].hwd;
      @(negedge clk);
      checkOutput($sformatf("row%0d_cpu_gnt", i), DW'(cpu_gnt), DW'(tbl[i].ecg));
      checkOutput($sformatf("row%0d_host_gnt", i), DW'(host_gnt), DW'(tbl[i].ehg));
      checkOutput($sformatf("row%0d_host_done", i), DW'(host_done), DW'(tbl[i].edone));
      checkOutput($sformatf("row%0d_mem_addr", i), DW'(mem_addr), DW'(tbl[i].eaddr));
      checkOutput($sformatf("row%0d_cpu_rvalid", i), DW'(cpu_rvalid), DW'(tbl[i].ecrv));
      checkOutput($sformatf("row%0d_host_rvalid", i), DW'(host_rvalid), DW'(tbl[i].ehrv));
      if (tbl[i].ecrv) checkOutput($sformatf("row%0d_cpu_rdata", i), cpu_rdata, tbl[i].erd);
      if (tbl[i].ehrv) checkOutput($sformatf("row%0d_host_rdata", i), host_rdata, tbl[i].erd);
      @(posedge clk); #1;
      #0;
      // the model runs on the same cycle through applyStimulus-style steps
      // below, so rewind: predict/commit using the sampled inputs
      modelPredict();
      modelCommit();
    end

    // reset asserted during beat 2 of a len-7 host read burst
    driveIdle();
    host_req = 1; host_we = 0; host_addr = 8'h08; host_len = 4'd7;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("midrst_pre_host_gnt", DW'(host_gnt), DW'(1));
    checkOutput("midrst_pre_host_rvalid", DW'(host_rvalid), DW'(1));
    reset = 0;
    #1;
    checkOutput("midrst_host_gnt", DW'(host_gnt), '0);
    checkOutput("midrst_host_rvalid", DW'(host_rvalid), '0);
    checkOutput("midrst_host_done", DW'(host_done), '0);
    checkOutput("midrst_cpu_gnt", DW'(cpu_gnt), '0);
    checkOutput("midrst_mem_we", DW'(mem_we), '0);
    modelReset();
    driveIdle();
    @(posedge clk);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h04;
    applyStimulus();
    driveIdle();
    checkOutput("postrst_cpu_rvalid", DW'(cpu_rvalid), DW'(1));
    checkOutput("postrst_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    applyStimulus();

    // randomized traffic against the reference model
    last_hg = 0;
    for (int c = 0; c < 400; c++) begin
      cpu_req   = ($urandom_range(0, 9) < 6);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 8'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      host_wdata = $urandom;
      if (m_in_burst) begin
        host_req = ($urandom_range(0, 19) != 0);
      end else if (!(host_req && !last_hg)) begin
        host_req  = ($urandom_range(0, 9) < 4);
        host_we   = 1'($urandom_range(0, 1));
        host_addr = 8'($urandom_range(0, 255));
        host_len  = 4'($urandom_range(0, 7));
      end
      applyStimulus();
      last_hg = e_hg;
    end
    driveIdle();
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
